walk_service_fsm: RTL
=====================

# walk_service_fsm

Consumer end of the pedestrian request path. Takes the latched walk request `wr` from the walk register and a `walk_window` grant from the main traffic controller, then sequences the pedestrian lamps through steady WALK, flashing DON'T WALK and a clearance interval. It drives `wr_reset` back to the walk register and raises `walk_busy` so the main controller holds vehicle signals at all-red until service ends.

## Interface
- `WALK_TICKS`, default 7: ticks of steady WALK (≥1).
- `FLASH_TICKS`, default 6: ticks of flashing DON'T WALK (≥1).
- `CLEAR_TICKS`, default 2: ticks of steady DON'T WALK before release (≥1).
- `CNT_W`, default 3: tick counter width; must hold max(param)−1.
- `clock`  in  1  system clock; single clock domain.
- `reset_sync`  in  1  reset, synchronous, active-high.
- `tick`  in  1  one-cycle timebase enable (e.g. 1 Hz strobe).
- `wr`  in  1  latched pedestrian request from walk register.
- `walk_window`  in  1  main controller grants walk (vehicles all-red).
- `walk_light`  out  1  WALK lamp.
- `dont_walk_light`  out  1  DON'T WALK lamp.
- `wr_reset`  out  1  clear request to walk register (level).
- `walk_busy`  out  1  service in progress; main FSM must hold all-red.

## Operation
- States: IDLE, WALK, FLASH, CLEAR. All outputs registered.
- IDLE: `dont_walk_light`=1, `walk_light`=0, `wr_reset`=0, `walk_busy`=0, counter=0. Ticks ignored.
- IDLE→WALK when `wr && walk_window` sampled at a clock edge. Either alone does nothing.
- WALK: `walk_light`=1, `dont_walk_light`=0, `wr_reset`=1, `walk_busy`=1. Counter increments on each `tick`. On tick with counter==WALK_TICKS−1 → FLASH, counter←0.
- FLASH: `walk_light`=0, `dont_walk_light`=1 on entry, toggles on every `tick` (including the exiting tick's toggle is suppressed: exit forces 1). `wr_reset`=1, `walk_busy`=1. On tick with counter==FLASH_TICKS−1 → CLEAR, counter←0.
- CLEAR: `dont_walk_light`=1 steady, `walk_light`=0, `wr_reset`=0 (new presses latch from here), `walk_busy`=1. On tick with counter==CLEAR_TICKS−1 → IDLE.
- `walk_window` is only sampled in IDLE; deassertion mid-service is ignored (`walk_busy` governs).
- `wr` outside IDLE is ignored; request re-asserted during CLEAR is serviced by a new IDLE→WALK after return to IDLE, if `walk_window` is still/again high.
- `walk_light` and `dont_walk_light` never both 1; never both 0 outside reset-free WALK/FLASH off phase (FLASH off phase: both 0 is legal).

## Timing
- Reset: any edge with `reset_sync`=1 → IDLE next cycle, outputs as IDLE, counter 0; overrides all, including mid-WALK/FLASH (`wr_reset` drops).
- Request latency: `wr && walk_window` at edge N → `walk_light`=1, `wr_reset`=1, `walk_busy`=1 visible after edge N. The walk register clears `wr` at edge N+1.
- Tick in same cycle as IDLE→WALK transition is not counted.
- Phase length: exactly WALK_TICKS / FLASH_TICKS / CLEAR_TICKS tick pulses; state change visible the cycle after the terminal tick.
- `walk_busy` falls the cycle after the last CLEAR tick; one IDLE cycle minimum before a new service can be visible (re-entry at earliest the following edge).
- Counter wraps never; it is cleared on every state change.

## Structure
- Shared package `traffic_pkg`: state encoding constants (IDLE=0, WALK=1, FLASH=2, CLEAR=3), default phase-length constants.
- One sub-module natural: `phase_tick_counter` (tick-enabled counter with clear and terminal-compare against a runtime limit, outputs `done`). FSM in top level.

## Test plan
Params WALK=3, FLASH=4, CLEAR=2; `tick` every 4 clocks.
- Reset then idle 20 clocks, `wr`=0 -> `dont_walk_light`=1, all else 0 throughout.
- `wr`=1, `walk_window`=0 for 10 clocks, then `walk_window`=1 -> WALK begins the cycle after the window rises; `wr_reset` high same cycle.
- Full service -> `walk_light` high for exactly 3 ticks, `dont_walk_light` toggles 1,0,1,0 across 4 FLASH ticks, steady 1 for 2 CLEAR ticks, `walk_busy` high for 9 ticks total.
- `reset_sync` pulsed at 2nd FLASH tick -> next cycle IDLE, `walk_busy`=0, `wr_reset`=0, counter 0.
- Press during WALK (`wr_sync` to register) -> ignored; press during CLEAR with `walk_window`=1 -> second service starts one cycle after return to IDLE.
- `walk_window` dropped mid-WALK -> sequence completes unchanged.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared definitions for the pedestrian walk service path:
//   - walk_state_t : FSM state encoding (IDLE=0, WALK=1, FLASH=2, CLEAR=3)
//   - DEF_*_TICKS  : default phase lengths in timebase ticks
//   - DEF_CNT_W    : default phase counter width
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_FLASH = 2'd2,
    ST_CLEAR = 2'd3
  } walk_state_t;

  localparam int DEF_WALK_TICKS  = 7;
  localparam int DEF_FLASH_TICKS = 6;
  localparam int DEF_CLEAR_TICKS = 2;
  localparam int DEF_CNT_W       = 3;

endpackage

// File: rtl/phase_tick_counter.sv
// phase_tick_counter
//   Tick-enabled phase counter with synchronous clear and a terminal compare
//   against a runtime last-count value.
// Ports:
//   clock      in  system clock
//   clear      in  synchronous clear (wins over en)
//   en         in  count enable (one timebase tick)
//   last_count in  terminal count value (phase length - 1)
//   count      out current count
//   done       out en && count == last_count (combinational, same cycle as
//                  the terminal tick)
module phase_tick_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] last_count,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign done = en && (count == last_count);

endmodule

// File: rtl/walk_service_fsm.sv
// walk_service_fsm
//   Consumer end of the pedestrian request path. On a latched request with
//   the vehicle all-red grant present, sequences the pedestrian lamps through
//   steady WALK, flashing DON'T WALK and a steady clearance interval.
//
//   Request/clear handshake with the walk register: wr is a level that stays
//   high until this block answers with wr_reset (a level). wr_reset is high
//   through WALK and FLASH and drops in CLEAR, so presses made during CLEAR
//   are held by the register and serviced after the return to IDLE.
//   walk_window is only looked at in IDLE; once service starts, walk_busy is
//   what the main controller must honour.
//
// Ports:
//   clock           in  system clock
//   reset_sync      in  synchronous active-high reset
//   tick            in  one-cycle timebase strobe
//   wr              in  latched pedestrian request
//   walk_window     in  main controller walk grant
//   walk_light      out WALK lamp
//   dont_walk_light out DON'T WALK lamp
//   wr_reset        out clear request to the walk register
//   walk_busy       out service in progress
//   state_dbg       out current FSM state (walk_state_t encoding)
//   count_dbg       out current phase tick count
module walk_service_fsm
  import traffic_pkg::*;
#(
  parameter int WALK_TICKS  = DEF_WALK_TICKS,
  parameter int FLASH_TICKS = DEF_FLASH_TICKS,
  parameter int CLEAR_TICKS = DEF_CLEAR_TICKS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset_sync,
  input  logic             tick,
  input  logic             wr,
  input  logic             walk_window,
  output logic             walk_light,
  output logic             dont_walk_light,
  output logic             wr_reset,
  output logic             walk_busy,
  output logic [1:0]       state_dbg,
  output logic [CNT_W-1:0] count_dbg
);

  localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_TICKS - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_TICKS - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_TICKS - 1);

  walk_state_t      state;
  logic [CNT_W-1:0] last_count;
  logic [CNT_W-1:0] count;
  logic             cnt_en;
  logic             cnt_clear;
  logic             phase_done;

  // Terminal count for the phase currently being timed.
  always_comb begin
    last_count = '0;
    case (state)
      ST_WALK:  last_count = WALK_LAST;
      ST_FLASH: last_count = FLASH_LAST;
      ST_CLEAR: last_count = CLEAR_LAST;
      default:  last_count = '0;
    endcase
  end

  // Holding the counter clear in IDLE means a tick arriving on the same edge
  // as IDLE->WALK is not counted. Clearing on phase_done resets it at every
  // phase change, so it never wraps.
  assign cnt_en    = tick && (state != ST_IDLE);
  assign cnt_clear = reset_sync || (state == ST_IDLE) || phase_done;

  phase_tick_counter #(
    .CNT_W(CNT_W)
  ) u_phase_cnt (
    .clock      (clock),
    .clear      (cnt_clear),
    .en         (cnt_en),
    .last_count (last_count),
    .count      (count),
    .done       (phase_done)
  );

  // State and all lamp/handshake outputs are registered together so each
  // output change lines up with the state change that causes it.
  always_ff @(posedge clock) begin
    if (reset_sync) begin
      state           <= ST_IDLE;
      walk_light      <= 1'b0;
      dont_walk_light <= 1'b1;
      wr_reset        <= 1'b0;
      walk_busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr && walk_window) begin
            state           <= ST_WALK;
            walk_light      <= 1'b1;
            dont_walk_light <= 1'b0;
            wr_reset        <= 1'b1;
            walk_busy       <= 1'b1;
          end
        end
        ST_WALK: begin
          if (phase_done) begin
            state           <= ST_FLASH;
            walk_light      <= 1'b0;
            dont_walk_light <= 1'b1;
          end
        end
        ST_FLASH: begin
          // The exiting tick lands on steady DON'T WALK instead of toggling.
          if (phase_done) begin
            state           <= ST_CLEAR;
            dont_walk_light <= 1'b1;
            wr_reset        <= 1'b0;
          end else if (tick) begin
            dont_walk_light <= ~dont_walk_light;
          end
        end
        ST_CLEAR: begin
          if (phase_done) begin
            state     <= ST_IDLE;
            walk_busy <= 1'b0;
          end
        end
        default: begin
          state           <= ST_IDLE;
          walk_light      <= 1'b0;
          dont_walk_light <= 1'b1;
          wr_reset        <= 1'b0;
          walk_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;
  assign count_dbg = count;

endmodule
